// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock controller: state encoding,
// default field width and the config validation rule.
package clk_div_pkg;

  localparam int unsigned CW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  // A config is usable when the ratio is at least 2 and both phases are non-empty.
  function automatic logic cfg_ok(input logic [31:0] div, input logic [31:0] high);
    return (div >= 32'd2) && (high >= 32'd1) && (high < div);
  endfunction

endpackage

// File: rtl/div_period_cnt.sv
// Period counter for the divided clock: wrap detection plus the registered
// out / period_start compare, evaluated on next-cycle values.
module div_period_cnt
  import clk_div_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          run_nxt,
  input  logic [CW-1:0] div,
  input  logic [CW-1:0] high_nxt,
  output logic          last_cycle_c,
  output logic          out,
  output logic          period_start
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign last_cycle_c = run && (cnt == (div - CW'(1)));

  // Restart from 0 on leaving IDLE, on every wrap, and whenever stopped.
  always_comb begin
    cnt_nxt = '0;
    if (run && run_nxt && !last_cycle_c) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      out          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      out          <= run_nxt && (cnt_nxt < high_nxt);
      period_start <= run_nxt && (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the divided-clock generator: start/stop sequencing
// and glitch-free ratio/duty changes applied only at period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CW       = CW_DEF,
  parameter int unsigned DEF_DIV  = 4,
  parameter int unsigned DEF_HIGH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_div,
  input  logic [CW-1:0] cfg_high,
  output logic          cfg_err,
  output logic          out,
  output logic          period_start,
  output logic          busy,
  output logic [CW-1:0] active_div
);

  state_t        state, state_nxt;
  logic [CW-1:0] active_high, pend_div, pend_high;
  logic [CW-1:0] div_nxt, high_nxt, pdiv_nxt, phigh_nxt;
  logic          last_cycle_c;
  logic          xfer_c, acc_c;

  assign xfer_c = cfg_valid && cfg_ready;
  assign acc_c  = xfer_c && cfg_ok(32'(cfg_div), 32'(cfg_high));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Stops and config switches only ever happen on the last cycle of a period.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (enable) state_nxt = ST_RUN;
      ST_RUN: begin
        if (last_cycle_c && !enable) state_nxt = ST_IDLE;
        else if (acc_c)              state_nxt = ST_PEND;
      end
      ST_PEND: if (last_cycle_c) state_nxt = enable ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    div_nxt   = active_div;
    high_nxt  = active_high;
    pdiv_nxt  = pend_div;
    phigh_nxt = pend_high;
    unique case (state)
      ST_IDLE: if (acc_c) begin
        div_nxt  = cfg_div;
        high_nxt = cfg_high;
      end
      ST_RUN: if (acc_c) begin
        // Accepted while stopping: no further period exists, so apply directly.
        if (state_nxt == ST_IDLE) begin
          div_nxt  = cfg_div;
          high_nxt = cfg_high;
        end else begin
          pdiv_nxt  = cfg_div;
          phigh_nxt = cfg_high;
        end
      end
      ST_PEND: if (last_cycle_c) begin
        div_nxt  = pend_div;
        high_nxt = pend_high;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_div  <= CW'(DEF_DIV);
      active_high <= CW'(DEF_HIGH);
      pend_div    <= CW'(DEF_DIV);
      pend_high   <= CW'(DEF_HIGH);
      cfg_err     <= 1'b0;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      active_div  <= div_nxt;
      active_high <= high_nxt;
      pend_div    <= pdiv_nxt;
      pend_high   <= phigh_nxt;
      cfg_err     <= xfer_c && !acc_c;
      cfg_ready   <= (state_nxt != ST_PEND);
      busy        <= (state_nxt != ST_IDLE);
    end
  end

  div_period_cnt #(.CW(CW)) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .run          (state != ST_IDLE),
    .run_nxt      (state_nxt != ST_IDLE),
    .div          (active_div),
    .high_nxt     (high_nxt),
    .last_cycle_c (last_cycle_c),
    .out          (out),
    .period_start (period_start)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: table of IDLE configs with pattern checks,
// plus hand sequences for mid-run switches, rejects, stop and async reset.
module tb_clk_div_ctrl;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_div;
  logic [CW-1:0] cfg_high;
  logic          cfg_err;
  logic          out;
  logic          period_start;
  logic          busy;
  logic [CW-1:0] active_div;

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(.CW(CW), .DEF_DIV(4), .DEF_HIGH(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div      (cfg_div),
    .cfg_high     (cfg_high),
    .cfg_err      (cfg_err),
    .out          (out),
    .period_start (period_start),
    .busy         (busy),
    .active_div   (active_div)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned div;
    int unsigned high;
    bit          exp_err;
    int unsigned exp_div;
    int unsigned exp_high;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic offer(input int unsigned d, input int unsigned h);
    cfg_valid = 1'b1;
    cfg_div   = CW'(d);
    cfg_high  = CW'(h);
  endtask

  // Counter positions k0..k1-1 of a running div/high pattern.
  task automatic run_pattern(input int unsigned d, input int unsigned h,
                             input int unsigned k0, input int unsigned k1);
    for (int unsigned k = k0; k < k1; k++) begin
      tick();
      chk($sformatf("out %0d/%0d k%0d", d, h, k), 32'(out), 32'((k % d) < h));
      chk($sformatf("ps %0d/%0d k%0d", d, h, k), 32'(period_start), 32'((k % d) == 0));
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
    end
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " out"}, 32'(out), 32'd0);
  endtask

  initial begin
    vecs[0] = '{6, 3, 1'b0, 6, 3};
    vecs[1] = '{1, 0, 1'b1, 6, 3};
    vecs[2] = '{5, 0, 1'b1, 6, 3};
    vecs[3] = '{5, 5, 1'b1, 6, 3};
    vecs[4] = '{3, 2, 1'b0, 3, 2};
    vecs[5] = '{2, 1, 1'b0, 2, 1};
    vecs[6] = '{7, 6, 1'b0, 7, 6};
    vecs[7] = '{4, 1, 1'b0, 4, 1};

    reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
    #12;
    chk("rst out", 32'(out), 32'd0);
    chk("rst ps", 32'(period_start), 32'd0);
    chk("rst err", 32'(cfg_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ready", 32'(cfg_ready), 32'd1);
    chk("rst div", 32'(active_div), 32'd4);

    // Defaults 4/1 straight out of reset.
    reset = 1'b1;
    enable = 1'b1;
    run_pattern(4, 1, 0, 8);
    chk("def busy", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_idle("def stop");

    // IDLE configs, accepted and rejected, each followed by two periods.
    foreach (vecs[i]) begin
      offer(vecs[i].div, vecs[i].high);
      tick();
      cfg_valid = 1'b0;
      chk($sformatf("v%0d err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d div", i), 32'(active_div), vecs[i].exp_div);
      chk($sformatf("v%0d ready", i), 32'(cfg_ready), 32'd1);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'd0);
      enable = 1'b1;
      run_pattern(vecs[i].exp_div, vecs[i].exp_high, 0, 2 * vecs[i].exp_div);
      enable = 1'b0;
      wait_idle($sformatf("v%0d stop", i));
    end

    // Running 4/1, 8/2 offered at cnt=1: current period completes first.
    enable = 1'b1;
    run_pattern(4, 1, 0, 2);
    offer(8, 2);
    tick();
    cfg_valid = 1'b0;
    chk("sw ready c2", 32'(cfg_ready), 32'd0);
    chk("sw out c2", 32'(out), 32'd0);
    chk("sw div c2", 32'(active_div), 32'd4);
    tick();
    chk("sw ready c3", 32'(cfg_ready), 32'd0);
    chk("sw out c3", 32'(out), 32'd0);
    chk("sw ps c3", 32'(period_start), 32'd0);
    tick();
    chk("sw out new", 32'(out), 32'd1);
    chk("sw ps new", 32'(period_start), 32'd1);
    chk("sw ready new", 32'(cfg_ready), 32'd1);
    chk("sw div new", 32'(active_div), 32'd8);
    run_pattern(8, 2, 1, 8);

    // Offer on the last cycle: the immediately next period keeps 8/2.
    offer(4, 1);
    tick();
    cfg_valid = 1'b0;
    chk("last ready", 32'(cfg_ready), 32'd0);
    chk("last div", 32'(active_div), 32'd8);
    chk("last out", 32'(out), 32'd1);
    chk("last ps", 32'(period_start), 32'd1);
    run_pattern(8, 2, 1, 8);
    tick();
    chk("last div new", 32'(active_div), 32'd4);
    chk("last ps new", 32'(period_start), 32'd1);
    chk("last out new", 32'(out), 32'd1);

    // Rejected configs while running leave 4/1 untouched.
    offer(1, 0);
    tick();
    chk("rej1 err", 32'(cfg_err), 32'd1);
    chk("rej1 out", 32'(out), 32'd0);
    offer(5, 0);
    tick();
    chk("rej2 err", 32'(cfg_err), 32'd1);
    chk("rej2 ready", 32'(cfg_ready), 32'd1);
    offer(5, 5);
    tick();
    chk("rej3 err", 32'(cfg_err), 32'd1);
    chk("rej3 div", 32'(active_div), 32'd4);
    cfg_valid = 1'b0;
    tick();
    chk("rej err clr", 32'(cfg_err), 32'd0);
    chk("rej out", 32'(out), 32'd1);
    chk("rej ps", 32'(period_start), 32'd1);
    run_pattern(4, 1, 1, 4);
    enable = 1'b0;
    wait_idle("rej stop");

    // Running 6/3, enable dropped at cnt=1: period finishes, then IDLE.
    offer(6, 3);
    tick();
    cfg_valid = 1'b0;
    enable = 1'b1;
    run_pattern(6, 3, 0, 2);
    enable = 1'b0;
    for (int unsigned k = 2; k < 6; k++) begin
      tick();
      chk($sformatf("stop out c%0d", k), 32'(out), 32'(k < 3));
      chk($sformatf("stop busy c%0d", k), 32'(busy), 32'd1);
    end
    tick();
    chk("stop out end", 32'(out), 32'd0);
    chk("stop busy end", 32'(busy), 32'd0);
    chk("stop ps end", 32'(period_start), 32'd0);

    // Async reset in the high phase of 8/2.
    offer(8, 2);
    tick();
    cfg_valid = 1'b0;
    enable = 1'b1;
    run_pattern(8, 2, 0, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst out", 32'(out), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst div", 32'(active_div), 32'd4);
    chk("arst ready", 32'(cfg_ready), 32'd1);
    enable = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    chk("post busy", 32'(busy), 32'd0);
    chk("post out", 32'(out), 32'd0);
    chk("post div", 32'(active_div), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
